// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the 2-to-1 SRAM-like bus arbiter.
package sram_arb_pkg;

    typedef logic arb_id_t;

    localparam arb_id_t ARB_ID_INST     = 1'b0;
    localparam arb_id_t ARB_ID_DATA     = 1'b1;
    localparam int      ARB_OUTSTANDING = 4;

endpackage

// File: rtl/arb_id_fifo.sv
// Outstanding-transaction ID FIFO; pointers carry one extra wrap bit to tell full from empty.
module arb_id_fifo
    import sram_arb_pkg::*;
#(
    parameter int DEPTH = ARB_OUTSTANDING
) (
    input  logic clk,
    input  logic resetn,
    input  logic push,
    input  logic pop,
    input  logic din,
    output logic dout,
    output logic full,
    output logic empty
);

    localparam int AW = $clog2(DEPTH);

    arb_id_t        mem [DEPTH];
    logic [AW:0]    wr_ptr;
    logic [AW:0]    rd_ptr;
    logic           do_push;
    logic           do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop & ~empty;
    // A push while full is accepted only when the head leaves in the same cycle.
    assign do_push = push & (~full | do_pop);
    assign dout    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= ARB_ID_INST;
        end else begin
            if (do_push) begin
                mem[wr_ptr[AW-1:0]] <= din;
                wr_ptr              <= wr_ptr + {{AW{1'b0}}, 1'b1};
            end
            if (do_pop) rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
        end
    end

endmodule

// File: rtl/sram_arb_2x1.sv
// Merges instruction (m0) and data (m1) initiators onto one SRAM-like responder.
// Define SRAM_ARB_RR_EN for round-robin arbitration; otherwise m1 has fixed priority.
module sram_arb_2x1
    import sram_arb_pkg::*;
#(
    parameter int OUTSTANDING = ARB_OUTSTANDING
) (
    input  logic        clk,
    input  logic        resetn,

    input  logic        m0_req,
    input  logic        m0_wr,
    input  logic [1:0]  m0_size,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic [31:0] m0_rdata,
    output logic        m0_addr_ok,
    output logic        m0_data_ok,

    input  logic        m1_req,
    input  logic        m1_wr,
    input  logic [1:0]  m1_size,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic [31:0] m1_rdata,
    output logic        m1_addr_ok,
    output logic        m1_data_ok,

    output logic        s_req,
    output logic        s_wr,
    output logic [1:0]  s_size,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    input  logic [31:0] s_rdata,
    input  logic        s_addr_ok,
    input  logic        s_data_ok
);

    logic    lock_vld;
    arb_id_t lock_id;
    arb_id_t grant;
    logic    granted_req;
    logic    handshake;
    logic    fifo_full;
    logic    fifo_empty;
    logic    head_id;
    logic    resp_vld;

`ifdef SRAM_ARB_RR_EN
    arb_id_t rr_last;
`endif

    always_comb begin
        grant = ARB_ID_INST;
        if (lock_vld) begin
            grant = lock_id;
        end else if (m0_req && m1_req) begin
`ifdef SRAM_ARB_RR_EN
            grant = ~rr_last;
`else
            grant = ARB_ID_DATA;
`endif
        end else if (m1_req) begin
            grant = ARB_ID_DATA;
        end
    end

    assign granted_req = (grant == ARB_ID_DATA) ? m1_req : m0_req;
    assign s_req       = granted_req & ~fifo_full;
    assign s_wr        = (grant == ARB_ID_DATA) ? m1_wr    : m0_wr;
    assign s_size      = (grant == ARB_ID_DATA) ? m1_size  : m0_size;
    assign s_addr      = (grant == ARB_ID_DATA) ? m1_addr  : m0_addr;
    assign s_wdata     = (grant == ARB_ID_DATA) ? m1_wdata : m0_wdata;

    assign handshake   = s_req & s_addr_ok;
    assign m0_addr_ok  = handshake & (grant == ARB_ID_INST);
    assign m1_addr_ok  = handshake & (grant == ARB_ID_DATA);

    // Responses arriving with nothing outstanding are dropped here.
    assign resp_vld    = s_data_ok & ~fifo_empty;
    assign m0_data_ok  = resp_vld & (head_id == ARB_ID_INST);
    assign m1_data_ok  = resp_vld & (head_id == ARB_ID_DATA);
    assign m0_rdata    = s_rdata;
    assign m1_rdata    = s_rdata;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            lock_vld <= 1'b0;
            lock_id  <= ARB_ID_INST;
        end else if (handshake) begin
            lock_vld <= 1'b0;
        end else if (s_req && !s_addr_ok) begin
            lock_vld <= 1'b1;
            lock_id  <= grant;
        end
    end

`ifdef SRAM_ARB_RR_EN
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)        rr_last <= ARB_ID_INST;
        else if (handshake) rr_last <= grant;
    end
`endif

    arb_id_fifo #(.DEPTH(OUTSTANDING)) u_id_fifo (
        .clk    (clk),
        .resetn (resetn),
        .push   (handshake),
        .pop    (resp_vld),
        .din    (grant),
        .dout   (head_id),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (resetn)
            assert (!(s_data_ok && fifo_empty))
            else $warning("sram_arb_2x1: s_data_ok with no outstanding transaction, response dropped");
    end
`endif

endmodule

// File: tb/tb_sram_arb_2x1.sv
// Directed bench for sram_arb_2x1 (default fixed-priority build).
module tb_sram_arb_2x1;

    logic        clk = 1'b0;
    logic        resetn;
    logic        m0_req, m0_wr, m1_req, m1_wr;
    logic [1:0]  m0_size, m1_size;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic [31:0] m0_rdata, m1_rdata;
    logic        m0_addr_ok, m0_data_ok, m1_addr_ok, m1_data_ok;
    logic        s_req, s_wr;
    logic [1:0]  s_size;
    logic [31:0] s_addr, s_wdata, s_rdata;
    logic        s_addr_ok, s_data_ok;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    sram_arb_2x1 dut (
        .clk(clk), .resetn(resetn),
        .m0_req(m0_req), .m0_wr(m0_wr), .m0_size(m0_size), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_rdata(m0_rdata), .m0_addr_ok(m0_addr_ok), .m0_data_ok(m0_data_ok),
        .m1_req(m1_req), .m1_wr(m1_wr), .m1_size(m1_size), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_rdata(m1_rdata), .m1_addr_ok(m1_addr_ok), .m1_data_ok(m1_data_ok),
        .s_req(s_req), .s_wr(s_wr), .s_size(s_size), .s_addr(s_addr), .s_wdata(s_wdata),
        .s_rdata(s_rdata), .s_addr_ok(s_addr_ok), .s_data_ok(s_data_ok)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic idle();
        m0_req = 0; m0_wr = 0; m0_size = 0; m0_addr = 0; m0_wdata = 0;
        m1_req = 0; m1_wr = 0; m1_size = 0; m1_addr = 0; m1_wdata = 0;
        s_rdata = 0; s_addr_ok = 0; s_data_ok = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_s_req"},   {31'b0, s_req}, 0);
        check({tag, "_addr_ok"}, {30'b0, m1_addr_ok, m0_addr_ok}, 0);
        check({tag, "_data_ok"}, {30'b0, m1_data_ok, m0_data_ok}, 0);
        check({tag, "_s_addr"},  s_addr, 0);
        check({tag, "_s_flds"},  {s_wdata[29:0], s_size}, 0);
    endtask

    // Respond once with rdata and check which initiator receives it.
    task automatic respond(input string tag, input logic [31:0] rd, input logic to_m1);
        s_data_ok = 1; s_rdata = rd;
        #2;
        check({tag, "_dok"}, {30'b0, m1_data_ok, m0_data_ok}, to_m1 ? 2 : 1);
        check({tag, "_rdata"}, to_m1 ? m1_rdata : m0_rdata, rd);
        tick();
        s_data_ok = 0; s_rdata = 0;
    endtask

    logic [31:0] il_rdata [3];
    logic        il_is_m1 [3];

    initial begin
        idle();
        resetn = 0;
        #2;
        check_all_zero("rst");
        #10 resetn = 1;
        tick();
        check_all_zero("idle");

        // Single m1 read
        m1_req = 1; m1_addr = 32'h1000_0000; m1_size = 2'd2; s_addr_ok = 1;
        #2;
        check("t1_s_req", {31'b0, s_req}, 1);
        check("t1_s_addr", s_addr, 32'h1000_0000);
        check("t1_s_size", {30'b0, s_size}, 2);
        check("t1_aok", {30'b0, m1_addr_ok, m0_addr_ok}, 2);
        tick();
        idle();
        #2;
        check("t1_aok_once", {30'b0, m1_addr_ok, m0_addr_ok}, 0);
        tick();
        respond("t1", 32'hDEAD_BEEF, 1'b1);

        // Contention with s_addr_ok low for 3 cycles: m1 wins and stays locked
        m0_req = 1; m0_addr = 32'h0000_0A00; m0_wr = 1; m0_wdata = 32'h0A0A_0A0A;
        m1_req = 1; m1_addr = 32'h0000_0B00; m1_wdata = 32'h0B0B_0B0B;
        for (int i = 0; i < 3; i++) begin
            #2;
            check("t2_wait_addr", s_addr, 32'h0000_0B00);
            check("t2_wait_aok", {30'b0, m1_addr_ok, m0_addr_ok}, 0);
            tick();
        end
        s_addr_ok = 1;
        #2;
        check("t2_m1_hs", {30'b0, m1_addr_ok, m0_addr_ok}, 2);
        check("t2_wdata", s_wdata, 32'h0B0B_0B0B);
        tick();
        m1_req = 0;
        #2;
        check("t2_m0_hs", {30'b0, m1_addr_ok, m0_addr_ok}, 1);
        check("t2_m0_addr", s_addr, 32'h0000_0A00);
        check("t2_m0_wr", {31'b0, s_wr}, 1);
        tick();
        idle();
        respond("t2_r1", 32'h0000_0011, 1'b1);
        respond("t2_r2", 32'h0000_0022, 1'b0);

        // Mid-lock switch: m1 arrives after m0 is locked
        m0_req = 1; m0_addr = 32'h0000_C000;
        tick();
        m1_req = 1; m1_addr = 32'h0000_D000;
        #2;
        check("t3_lock_addr", s_addr, 32'h0000_C000);
        check("t3_lock_aok", {30'b0, m1_addr_ok, m0_addr_ok}, 0);
        tick();
        s_addr_ok = 1;
        #2;
        check("t3_m0_hs", {30'b0, m1_addr_ok, m0_addr_ok}, 1);
        tick();
        m0_req = 0;
        #2;
        check("t3_m1_addr", s_addr, 32'h0000_D000);
        check("t3_m1_hs", {30'b0, m1_addr_ok, m0_addr_ok}, 2);
        tick();
        idle();
        respond("t3_r1", 32'h0000_0C0C, 1'b0);
        respond("t3_r2", 32'h0000_0D0D, 1'b1);

        // Fill the ID FIFO with m0 transactions
        m0_req = 1; m0_addr = 32'h0000_F000; s_addr_ok = 1;
        for (int i = 0; i < 4; i++) begin
            #2;
            check("t4_fill_hs", {31'b0, m0_addr_ok}, 1);
            tick();
        end
        #2;
        check("t4_full_sreq", {31'b0, s_req}, 0);
        check("t4_full_aok", {31'b0, m0_addr_ok}, 0);
        tick();
        check("t4_full_sreq2", {31'b0, s_req}, 0);
        s_data_ok = 1; s_rdata = 32'h0000_0044;
        #2;
        check("t4_pop_dok", {30'b0, m1_data_ok, m0_data_ok}, 1);
        check("t4_pop_sreq", {31'b0, s_req}, 0);
        tick();
        s_data_ok = 0;
        #2;
        check("t4_reassert", {31'b0, s_req}, 1);
        check("t4_reassert_aok", {31'b0, m0_addr_ok}, 1);
        tick();
        idle();
        for (int i = 0; i < 4; i++) respond("t4_drain", 32'h100 + i, 1'b0);
        #2;
        check("t4_empty_sreq", {31'b0, s_req}, 0);

        // Interleaved m0, m1, m0 accepted then answered in order
        il_rdata = '{32'd1, 32'd2, 32'd3};
        il_is_m1 = '{1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 3; i++) begin
            idle();
            if (il_is_m1[i]) begin m1_req = 1; m1_addr = 32'h2000 + i; end
            else             begin m0_req = 1; m0_addr = 32'h2000 + i; end
            s_addr_ok = 1;
            #2;
            check("t5_hs", {30'b0, m1_addr_ok, m0_addr_ok}, il_is_m1[i] ? 2 : 1);
            tick();
        end
        idle();
        for (int i = 0; i < 3; i++) respond("t5_resp", il_rdata[i], il_is_m1[i]);

        // Reset with two outstanding, then a stray response afterwards
        m0_req = 1; s_addr_ok = 1;
        tick();
        m0_req = 0; m1_req = 1;
        tick();
        idle();
        resetn = 0;
        #2;
        check_all_zero("t6_in_rst");
        tick();
        resetn = 1;
        tick();
        s_data_ok = 1; s_rdata = 32'h0000_0055;
        #2;
        check("t6_stray_dok", {30'b0, m1_data_ok, m0_data_ok}, 0);
        tick();
        idle();
        m1_req = 1; m1_addr = 32'h3000; s_addr_ok = 1;
        #2;
        check("t6_after_hs", {31'b0, m1_addr_ok}, 1);
        tick();
        idle();
        respond("t6_after", 32'h0000_0066, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
